dff: RTL and testbench

DFF -- requirements
Module: dff

---
 rtl/dff.sv | 72 +++++++
 tb/tb_dff.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module   : dff
// Brief    : Parameterised clock-enabled shift pipeline of DEPTH registers
//            with a fill counter behind o_valid. Defining DFF_FILL_CNT_EN
//            exposes the fill count on o_fill.
// Revision : 1.0 - initial release
// ============================================================================
module dff #(
    parameter int                  WIDTH   = 1,
    parameter int                  DEPTH   = 1,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [WIDTH-1:0]               i_d,
    output logic [WIDTH-1:0]               o_q,
`ifdef DFF_FILL_CNT_EN
    output logic [$clog2(DEPTH+1)-1:0]     o_fill,
`endif
    output logic                           o_valid
);

    localparam int                  FILL_W     = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0]   c_fill_max = FILL_W'(DEPTH);

    logic [WIDTH-1:0]   r_stage_q [DEPTH];
    logic [WIDTH-1:0]   w_stage_d [DEPTH];
    logic [FILL_W-1:0]  r_fill_q;
    logic [FILL_W-1:0]  w_fill_d;
    logic               r_valid_q;
    logic               w_valid_d;

    always_comb begin
        w_stage_d = r_stage_q;
        w_fill_d  = r_fill_q;
        if (i_en) begin
            w_stage_d[0] = i_d;
            for (int k = 1; k < DEPTH; k++) begin
                w_stage_d[k] = r_stage_q[k-1];
            end
            if (r_fill_q != c_fill_max) begin
                w_fill_d = r_fill_q + 1'b1;
            end
        end
        // Valid is registered from the next fill count so it never glitches
        w_valid_d = (w_fill_d == c_fill_max);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage_q[k] <= RST_VAL;
            end
            r_fill_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_stage_q <= w_stage_d;
            r_fill_q  <= w_fill_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_q     = r_stage_q[DEPTH-1];
    assign o_valid = r_valid_q;
`ifdef DFF_FILL_CNT_EN
    assign o_fill  = r_fill_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff
// Brief    : Self-checking bench for dff: a 1x1 and a 4x8 instance compared
//            every cycle against a queue-based model, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff;

    logic       clk;
    logic       rst1, en1, d1;
    logic       rst4, en4;
    logic [7:0] d4;
    logic       q1, v1;
    logic [7:0] q4;
    logic       v4;
    logic       f1;
    logic [2:0] f4;

    int n_cmp;
    int n_err;

    // Reference model: the last DEPTH enabled samples since reset
    logic       h1[$];
    logic [7:0] h4[$];
    bit         known1, known4;

    dff #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst1),
        .i_en    (en1),
        .i_d     (d1),
        .o_q     (q1),
`ifdef DFF_FILL_CNT_EN
        .o_fill  (f1),
`endif
        .o_valid (v1)
    );

    dff #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u_dut4 (
        .i_clk   (clk),
        .i_rst   (rst4),
        .i_en    (en4),
        .i_d     (d4),
        .o_q     (q4),
`ifdef DFF_FILL_CNT_EN
        .o_fill  (f4),
`endif
        .o_valid (v4)
    );

`ifndef DFF_FILL_CNT_EN
    assign f1 = 1'b0;
    assign f4 = 3'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst1) begin
            h1.delete();
            known1 = 1'b1;
        end else if (en1 === 1'b1) begin
            h1.push_back(d1);
            if (h1.size() > 1) void'(h1.pop_front());
        end
        if (rst4) begin
            h4.delete();
            known4 = 1'b1;
        end else if (en4 === 1'b1) begin
            h4.push_back(d4);
            if (h4.size() > 4) void'(h4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (known1) begin
            check("m1_q",     64'(q1), 64'((h1.size() == 1) ? h1[0] : 1'b0));
            check("m1_valid", 64'(v1), 64'(h1.size() == 1));
`ifdef DFF_FILL_CNT_EN
            check("m1_fill",  64'(f1), 64'(h1.size()));
`endif
        end
        if (known4) begin
            check("m4_q",     64'(q4), 64'((h4.size() == 4) ? h4[0] : 8'hA5));
            check("m4_valid", 64'(v4), 64'(h4.size() == 4));
`ifdef DFF_FILL_CNT_EN
            check("m4_fill",  64'(f4), 64'(h4.size()));
`endif
        end
    end

    // Inputs are applied 1 time unit after a rising edge; step waits for the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pin_fill4(input string name, input int exp);
`ifdef DFF_FILL_CNT_EN
        check(name, 64'(f4), 64'(exp));
`endif
    endtask

    initial begin
        logic       smp;
        logic [7:0] vals [5];
        n_cmp = 0; n_err = 0;
        known1 = 1'b0; known4 = 1'b0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;

        rst1 = 1'b1; en1 = 1'b0; d1 = 1'b1;
        rst4 = 1'b1; en4 = 1'b1; d4 = 8'hFF;
        #1;
        step(); step();
        check("rst1_q", 64'(q1), 64'd0);
        check("rst1_valid", 64'(v1), 64'd0);
        check("rst4_q", 64'(q4), 64'hA5);
        check("rst4_valid", 64'(v4), 64'd0);
        pin_fill4("rst4_fill", 0);

        rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
        step();
        check("rel1_q", 64'(q1), 64'd1);
        check("rel1_valid", 64'(v1), 64'd1);

        // Plain D flip-flop: i_d wiggles mid-cycle, only the edge sample counts
        for (int i = 0; i < 11; i++) begin
            d1 = 1'($urandom);
            #5;
            smp = 1'($urandom);
            d1 = smp;
            step();
            check("ff1_q", 64'(q1), 64'(smp));
        end

        rst4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d4 = vals[i];
            step();
            pin_fill4("fill4_seq", (i < 4) ? i + 1 : 4);
            if (i < 3) begin
                check("lat4_q_pre", 64'(q4), 64'hA5);
                check("lat4_valid_pre", 64'(v4), 64'd0);
            end
        end
        check("lat4_q_5th", 64'(q4), 64'h22);
        check("lat4_valid", 64'(v4), 64'd1);

        en4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4 = 8'($urandom);
            step();
            check("hold4_q", 64'(q4), 64'h22);
            check("hold4_valid", 64'(v4), 64'd1);
            pin_fill4("hold4_fill", 4);
        end
        en4 = 1'b1; d4 = 8'h66;
        step();
        check("resume4_q", 64'(q4), 64'h33);

        // Random traffic on both instances, occasional resets
        for (int i = 0; i < 300; i++) begin
            rst1 = ($urandom_range(0, 19) == 0);
            en1  = 1'($urandom);
            d1   = 1'($urandom);
            rst4 = ($urandom_range(0, 29) == 0);
            en4  = ($urandom_range(0, 3) != 0);
            d4   = 8'($urandom);
            step();
        end

        rst1 = 1'b0; rst4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4 = 8'(i + 1);
            step();
        end
        check("full4_valid", 64'(v4), 64'd1);
        check("full4_q", 64'(q4), 64'h01);
        rst4 = 1'b1; en4 = 1'b1; d4 = 8'h3C;
        step();
        check("prio4_q", 64'(q4), 64'hA5);
        check("prio4_valid", 64'(v4), 64'd0);
        pin_fill4("prio4_fill", 0);
        rst4 = 1'b0; d4 = 8'h77;
        step();
        pin_fill4("restart4_fill", 1);
        check("restart4_valid", 64'(v4), 64'd0);
        check("restart4_q", 64'(q4), 64'hA5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
